// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer controller.
package reaction_pkg;

    localparam logic [1:0] FLAG_CLEAR = 2'b00;
    localparam logic [1:0] FLAG_HOLD  = 2'b01;
    localparam logic [1:0] FLAG_RUN   = 2'b10;

    localparam logic [9:0] MAX_MS = 10'd999;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        GO,
        STOP,
        DONE,
        FOUL
    } state_t;

    function automatic logic [1:0] state_flag(input state_t s);
        logic [1:0] f;
        f = FLAG_CLEAR;
        unique case (s)
            GO:         f = FLAG_RUN;
            STOP, DONE: f = FLAG_HOLD;
            default:    f = FLAG_CLEAR;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_btn_conditioner.sv
// Button conditioner: 2-FF synchroniser, ms-tick debounce and rising-edge pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ms_tick,
    input  logic btn_raw,
    output logic pulse
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic          prev_q, prev_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = btn_raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        prev_d   = stable_q;
        // a level change is accepted only after DEBOUNCE_MS ticks of persistence
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (ms_tick) begin
            if (cnt_q == DW'(DEBOUNCE_MS - 1)) begin
                stable_d = s2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = stable_q & ~prev_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer control FSM: random wait, go lamp, ms counter control,
// result latch, false-start and best-time tracking.
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int          CLK_PER_MS   = 50000,
    parameter int          DEBOUNCE_MS  = 10,
    parameter int          DELAY_MIN_MS = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_react,
    input  logic [9:0] counter_value,
    output logic [1:0] counter_flag,
    output logic       led_go,
    output logic [9:0] result,
    output logic       result_valid,
    output logic       timeout,
    output logic       false_start,
    output logic [9:0] best
);

    localparam int PW = $clog2(CLK_PER_MS + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          ms_tick;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          start_p;
    logic          react_p;

    state_t        state_q, state_d;
    logic [11:0]   wait_q, wait_d;
    logic          stop_q, stop_d;
    logic          arm;

    logic [1:0]    flag_q, flag_d;
    logic          led_go_q, led_go_d;
    logic [9:0]    result_q, result_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic          fs_q, fs_d;
    logic [9:0]    best_q, best_d;

    btn_conditioner #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_start (
        .clk     (clk_50M),
        .rst_n   (rst_n),
        .ms_tick (ms_tick),
        .btn_raw (btn_start),
        .pulse   (start_p)
    );

    btn_conditioner #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_react (
        .clk     (clk_50M),
        .rst_n   (rst_n),
        .ms_tick (ms_tick),
        .btn_raw (btn_react),
        .pulse   (react_p)
    );

    assign ms_tick = (presc_q == PW'(CLK_PER_MS - 1));

    always_comb begin
        presc_d = ms_tick ? '0 : presc_q + PW'(1);
        lfsr_d  = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        stop_d    = stop_q;
        arm       = 1'b0;
        result_d  = result_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        fs_d      = fs_q;
        best_d    = best_q;

        unique case (state_q)
            IDLE, DONE, FOUL: begin
                if (start_p) arm = 1'b1;
            end
            ARMED: begin
                if (react_p) begin
                    state_d = FOUL;
                    fs_d    = 1'b1;
                end else if (wait_q == '0) begin
                    state_d = GO;
                end else if (ms_tick) begin
                    wait_d = wait_q - 12'd1;
                end
            end
            GO: begin
                // saturation wins over a simultaneous react press
                if (counter_value == MAX_MS) begin
                    state_d   = STOP;
                    timeout_d = 1'b1;
                    stop_d    = 1'b0;
                end else if (react_p) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (stop_q) begin
                    state_d  = DONE;
                    result_d = counter_value;
                    valid_d  = 1'b1;
                    if (!timeout_q && counter_value < best_q) begin
                        best_d = counter_value;
                    end
                end else begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arm) begin
            state_d   = ARMED;
            wait_d    = 12'(DELAY_MIN_MS) + {1'b0, lfsr_q[10:0]};
            valid_d   = 1'b0;
            timeout_d = 1'b0;
            fs_d      = 1'b0;
        end

        // outputs follow the next state so they change on the same edge
        flag_d   = state_flag(state_d);
        led_go_d = (state_d == GO);
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            presc_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            state_q   <= IDLE;
            wait_q    <= '0;
            stop_q    <= 1'b0;
            flag_q    <= FLAG_CLEAR;
            led_go_q  <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            fs_q      <= 1'b0;
            best_q    <= MAX_MS;
        end else begin
            presc_q   <= presc_d;
            lfsr_q    <= lfsr_d;
            state_q   <= state_d;
            wait_q    <= wait_d;
            stop_q    <= stop_d;
            flag_q    <= flag_d;
            led_go_q  <= led_go_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            fs_q      <= fs_d;
            best_q    <= best_d;
        end
    end

    assign counter_flag = flag_q;
    assign led_go       = led_go_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout      = timeout_q;
    assign false_start  = fs_q;
    assign best         = best_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl with a modelled ms counter.
module tb_reaction_timer_ctrl;

    localparam int PRESS_EDGE = 10;
    // first ms tick edge at least 3 edges after the press: debounce accept
    localparam int LOAD_EDGE  = 16;
    localparam int GO_EDGE    = LOAD_EDGE + 1 + 4 * 1000;

    function automatic logic [15:0] back_seed(input logic [15:0] v,
                                              input int n);
        logic [15:0] s;
        s = v;
        for (int i = 0; i < n; i++) begin
            s = {s[0] ^ s[14] ^ s[13] ^ s[11], s[15:1]};
        end
        return s;
    endfunction

    localparam logic [15:0] SEED = back_seed(16'h8000, LOAD_EDGE);

    typedef enum int {EV_RESET, EV_GO, EV_RESULT, EV_FOUL} ev_t;

    typedef struct {
        ev_t        kind;
        int         go_edge;
        logic [9:0] result;
        logic       timeout;
        logic [9:0] best;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_react = 1'b0;
    logic [9:0] counter_value;
    logic [1:0] counter_flag;
    logic       led_go;
    logic [9:0] result;
    logic       result_valid;
    logic       timeout;
    logic       false_start;
    logic [9:0] best;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [9:0] cnt_m = '0;
    logic [1:0] ph = '0;
    int         ecount = 0;
    logic       rst_seen = 1'b0;
    logic       p_rst = 1'b0;
    logic       p_led = 1'b0;
    logic       p_rv = 1'b0;
    logic       p_fs = 1'b0;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(
        .CLK_PER_MS   (4),
        .DEBOUNCE_MS  (1),
        .DELAY_MIN_MS (1000),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk_50M       (clk),
        .rst_n         (rst_n),
        .btn_start     (btn_start),
        .btn_react     (btn_react),
        .counter_value (counter_value),
        .counter_flag  (counter_flag),
        .led_go        (led_go),
        .result        (result),
        .result_valid  (result_valid),
        .timeout       (timeout),
        .false_start   (false_start),
        .best          (best)
    );

    assign counter_value = cnt_m;

    // external ms counter driven by counter_flag
    always @(posedge clk) begin
        rst_seen <= !rst_n;
        if (!rst_n) begin
            ph     <= '0;
            cnt_m  <= '0;
            ecount <= 0;
        end else begin
            ph     <= ph + 2'd1;
            ecount <= ecount + 1;
            if (counter_flag == 2'b00) begin
                cnt_m <= '0;
            end else if (counter_flag == 2'b10 && ph == 2'd3 && cnt_m < 10'd999) begin
                cnt_m <= cnt_m + 10'd1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic handle(input ev_t ev);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s expected none", ev.name());
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", int'(ev), int'(e.kind));
            if (ev == e.kind) begin
                case (ev)
                    EV_RESET: begin
                        chk("rst_flag", counter_flag, 0);
                        chk("rst_led_go", led_go, 0);
                        chk("rst_best", best, 999);
                        chk("rst_result_valid", result_valid, 0);
                        chk("rst_result", result, 0);
                        chk("rst_timeout", timeout, 0);
                        chk("rst_false_start", false_start, 0);
                    end
                    EV_GO: begin
                        chk("go_flag", counter_flag, 2);
                        if (e.go_edge >= 0) chk("go_edge", ecount, e.go_edge);
                    end
                    EV_RESULT: begin
                        chk("res_value", result, e.result);
                        chk("res_timeout", timeout, e.timeout);
                        chk("res_best", best, e.best);
                        chk("res_flag", counter_flag, 1);
                        chk("res_led_go", led_go, 0);
                    end
                    default: begin
                        chk("foul_flag", counter_flag, 0);
                        chk("foul_led_go", led_go, 0);
                        chk("foul_result_valid", result_valid, 0);
                    end
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_seen && !p_rst)            handle(EV_RESET);
        else if (led_go && !p_led)         handle(EV_GO);
        else if (result_valid && !p_rv)    handle(EV_RESULT);
        else if (false_start && !p_fs)     handle(EV_FOUL);
        p_rst <= rst_seen;
        p_led <= led_go;
        p_rv  <= result_valid;
        p_fs  <= false_start;
    end

    function automatic exp_t mk(ev_t k, int ge, int r, int t, int b);
        exp_t e;
        e.kind    = k;
        e.go_edge = ge;
        e.result  = 10'(r);
        e.timeout = t[0];
        e.best    = 10'(b);
        return e;
    endfunction

    task automatic press(input bit react);
        if (react) btn_react = 1'b1;
        else       btn_start = 1'b1;
        repeat (12) @(negedge clk);
        btn_react = 1'b0;
        btn_start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_sig(input string name, input int sel, input int bound);
        int  i;
        bit  seen;
        i = 0;
        seen = 1'b0;
        while (!seen && i < bound) begin
            case (sel)
                0:       seen = led_go;
                1:       seen = result_valid;
                default: seen = false_start;
            endcase
            if (!seen) begin
                @(negedge clk);
                i++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: still low after %0d cycles", name, i);
        end
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n, input int exp_best, input int go_edge);
        exp_q.push_back(mk(EV_GO, go_edge, 0, 0, 0));
        exp_q.push_back(mk(EV_RESULT, -1, n, 0, exp_best));
        press(1'b0);
        wait_sig("wait_go", 0, 13500);
        repeat (4 * n - 5) @(negedge clk);
        press(1'b1);
        wait_sig("wait_result", 1, 4500);
    endtask

    initial begin
        exp_q.push_back(mk(EV_RESET, -1, 0, 0, 999));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        while (ecount != PRESS_EDGE) @(negedge clk);

        run(250, 250, GO_EDGE);

        exp_q.push_back(mk(EV_FOUL, -1, 0, 0, 0));
        press(1'b0);
        press(1'b1);
        wait_sig("wait_foul", 2, 200);

        exp_q.push_back(mk(EV_GO, -1, 0, 0, 0));
        exp_q.push_back(mk(EV_RESULT, -1, 999, 1, 250));
        press(1'b0);
        wait_sig("wait_go", 0, 13500);
        wait_sig("wait_timeout", 1, 4500);

        exp_q.push_back(mk(EV_RESET, -1, 0, 0, 999));
        rst_pulse();
        run(400, 400, -1);
        run(180, 180, -1);
        run(300, 180, -1);

        exp_q.push_back(mk(EV_GO, -1, 0, 0, 0));
        exp_q.push_back(mk(EV_RESET, -1, 0, 0, 999));
        press(1'b0);
        wait_sig("wait_go", 0, 13500);
        repeat (3) @(negedge clk);
        rst_pulse();
        repeat (20) @(negedge clk);

        chk("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
